// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard-unit holds, branch redirect
// and the IF/ID fields presented to decode and hazard detection.
interface fetch_stage_if;
  localparam int unsigned XLEN = 16;
  localparam int unsigned FLEN = 4;

  logic [XLEN-1:0] imem_data;
  logic            PC_Hold;
  logic            IF_ID_Hold;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] IF_ID_Instr;
  logic [XLEN-1:0] IF_ID_PC;
  logic            IF_ID_Valid;
  logic [FLEN-1:0] Opcode;
  logic [FLEN-1:0] IF_ID_Op1;
  logic [FLEN-1:0] IF_ID_Op2;
  logic [FLEN-1:0] FunctionCode;
  logic            halted;
  logic            misalign;
  logic [XLEN-1:0] stall_count;
  logic            stall_timeout;

  // Fetch stage side.
  modport master (
    input  imem_data, PC_Hold, IF_ID_Hold, branch_taken, branch_target,
    output imem_addr, IF_ID_Instr, IF_ID_PC, IF_ID_Valid, Opcode, IF_ID_Op1,
           IF_ID_Op2, FunctionCode, halted, misalign, stall_count, stall_timeout
  );

  // Memory / hazard unit / downstream side.
  modport slave (
    output imem_data, PC_Hold, IF_ID_Hold, branch_taken, branch_target,
    input  imem_addr, IF_ID_Instr, IF_ID_PC, IF_ID_Valid, Opcode, IF_ID_Op1,
           IF_ID_Op2, FunctionCode, halted, misalign, stall_count, stall_timeout
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: PC ownership, branch redirect/flush,
// halt freeze and stall statistics for the hazard unit.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OP     = 4'b1111,
  parameter logic [7:0]  STALL_LIMIT = 8'd64
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int unsigned XLEN = 16;
  localparam int unsigned CW   = 8;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            valid;
  logic            misalign;
  logic [XLEN-1:0] stall_count;
  logic [CW-1:0]   consec;
  logic            stall_timeout;

  logic            stall_cond;
  logic [CW-1:0]   consec_inc;

  // A stall edge is a held PC while running and not being redirected.
  always_comb begin
    stall_cond = 1'b0;
    consec_inc = consec;
    stall_cond = bus.PC_Hold && (state == ST_RUN) && !bus.branch_taken;
    if (consec != {CW{1'b1}}) consec_inc = consec + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_RUN;
      pc            <= RESET_PC;
      instr         <= NOP_INSTR;
      instr_pc      <= '0;
      valid         <= 1'b0;
      misalign      <= 1'b0;
      stall_count   <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      misalign <= bus.branch_taken & bus.branch_target[0];

      // Redirect wins in either state and cancels any speculative halt.
      if (bus.branch_taken) begin
        state    <= ST_RUN;
        pc       <= {bus.branch_target[XLEN-1:1], 1'b0};
        instr    <= NOP_INSTR;
        instr_pc <= '0;
        valid    <= 1'b0;
      end else if (state == ST_RUN) begin
        if (!bus.PC_Hold) pc <= pc + XLEN'(2);
        if (bus.IF_ID_Hold) begin
          instr    <= bus.imem_data;
          instr_pc <= pc;
          valid    <= 1'b1;
        end
        if (valid && (instr[15:12] == HALT_OP)) state <= ST_HALT;
      end

      if (stall_cond) begin
        if (stall_count != {XLEN{1'b1}}) stall_count <= stall_count + XLEN'(1);
        consec <= consec_inc;
        if (consec_inc >= STALL_LIMIT) stall_timeout <= 1'b1;
      end else begin
        consec <= '0;
      end
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.IF_ID_Instr   = instr;
  assign bus.IF_ID_PC      = instr_pc;
  assign bus.IF_ID_Valid   = valid;
  assign bus.Opcode        = instr[15:12];
  assign bus.IF_ID_Op1     = instr[11:8];
  assign bus.IF_ID_Op2     = instr[7:4];
  assign bus.FunctionCode  = instr[3:0];
  assign bus.halted        = (state == ST_HALT);
  assign bus.misalign      = misalign;
  assign bus.stall_count   = stall_count;
  assign bus.stall_timeout = stall_timeout;
endmodule
